// File: rtl/mux_2x1_if.sv
// Signal bundle for the 2-to-1 word mux: data/select driven by the master,
// combinational and registered results returned by the slave.
interface mux_2x1_if #(
   parameter int WIDTH = 5
);
   logic [WIDTH-1:0] I0;
   logic [WIDTH-1:0] I1;
   logic             sel;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_q;
   logic             sel_q;

   modport master (output I0, I1, sel, input  out, out_q, sel_q);
   modport slave  (input  I0, I1, sel, output out, out_q, sel_q);
endinterface

// File: rtl/mux_2x1.sv
// 2-to-1 word mux for rt/rd destination select: zero-latency combinational
// result plus a one-cycle registered copy of the result and the select.
module mux_2x1 #(
   parameter int WIDTH = 5
) (
   input  logic      clk,
   input  logic      rst_n,
   mux_2x1_if.slave  mux_bus
);
   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] r_out_q;
   logic             r_sel_q;

   // Ternary keeps simulation X-merge: an unknown sel yields I0 where the inputs agree.
   assign w_out = mux_bus.sel ? mux_bus.I1 : mux_bus.I0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_q <= '0;
         r_sel_q <= 1'b0;
      end else begin
         r_out_q <= w_out;
         r_sel_q <= mux_bus.sel;
      end
   end

   assign mux_bus.out   = w_out;
   assign mux_bus.out_q = r_out_q;
   assign mux_bus.sel_q = r_sel_q;
endmodule

// File: tb/tb_mux_2x1.sv
// Directed plus randomized checks of mux_2x1 against a table-lookup reference.
module tb_mux_2x1;
   localparam int W = 5;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mux_2x1_if #(.WIDTH(W)) mif ();

   mux_2x1 #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mux_bus (mif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: select an entry of a two-element table indexed by sel.
   function automatic logic [W-1:0] ref_mux(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
      logic [W-1:0] tbl [2];
      tbl[0] = a;
      tbl[1] = b;
      return tbl[int'(s)];
   endfunction

   // Expected registered values: what was selected at the last rising edge.
   logic [W-1:0] m_q;
   logic         m_s;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q <= '0;
         m_s <= 1'b0;
      end else begin
         m_q <= ref_mux(mif.I0, mif.I1, mif.sel);
         m_s <= mif.sel;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] exp);
      chk(tag, 32'(mif.out), 32'(exp));
   endtask

   task automatic chk_reg(input string tag);
      chk({tag, "_out_q"}, 32'(mif.out_q), 32'(m_q));
      chk({tag, "_sel_q"}, 32'(mif.sel_q), 32'(m_s));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      mif.I0 = '0;
      mif.I1 = '0;
      mif.sel = 1'b0;

      // Reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      chk_out("rst_out", 5'b00000);
      chk("rst_out_q", 32'(mif.out_q), 32'd0);
      chk("rst_sel_q", 32'(mif.sel_q), 32'd0);

      // Release, sel=0
      @(negedge clk);
      rst_n  = 1'b1;
      mif.I0 = 5'b01010;
      mif.I1 = 5'b00110;
      mif.sel = 1'b0;
      #1 chk_out("sel0_out", 5'b01010);
      @(posedge clk); #1;
      chk("sel0_out_q", 32'(mif.out_q), 32'(5'b01010));
      chk("sel0_sel_q", 32'(mif.sel_q), 32'd0);

      // sel=1, registered copy lags by one edge
      @(negedge clk);
      mif.sel = 1'b1;
      #1 chk_out("sel1_out", 5'b00110);
      chk("sel1_out_q_before", 32'(mif.out_q), 32'(5'b01010));
      @(posedge clk); #1;
      chk("sel1_out_q", 32'(mif.out_q), 32'(5'b00110));
      chk("sel1_sel_q", 32'(mif.sel_q), 32'd1);

      // Toggle sel 0,1,0 at 50 ns intervals
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         mif.sel = (i == 1);
         #1 chk_out("tog_out", (i == 1) ? 5'b00110 : 5'b01010);
         #3 chk_out("tog_out_mid", (i == 1) ? 5'b00110 : 5'b01010);
         #4 chk_reg("tog");
         #42;
      end

      // Mid-run reset with sel=1, off the clock edge
      @(negedge clk);
      mif.sel = 1'b1;
      @(posedge clk); #2;
      chk("pre_rst_out_q", 32'(mif.out_q), 32'(5'b00110));
      rst_n = 1'b0;
      #1;
      chk("midrst_out_q", 32'(mif.out_q), 32'd0);
      chk("midrst_sel_q", 32'(mif.sel_q), 32'd0);
      chk_out("midrst_out", 5'b00110);

      // Edge values, no bit mixing
      @(negedge clk);
      rst_n  = 1'b1;
      mif.I0 = 5'b11111;
      mif.I1 = 5'b00000;
      for (int i = 0; i < 4; i++) begin
         mif.sel = i[0];
         #1 chk_out("edge_out", i[0] ? 5'b00000 : 5'b11111);
         @(posedge clk); #1;
         chk_reg("edge");
         @(negedge clk);
      end

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 60; i++) begin
         mif.I0  = W'($urandom);
         mif.I1  = W'($urandom);
         mif.sel = 1'($urandom);
         #1 chk_out("rnd_out", ref_mux(mif.I0, mif.I1, mif.sel));
         if ($urandom_range(0, 9) == 0) begin
            rst_n = 1'b0;
            #1 chk_reg("rnd_rst");
            #1 rst_n = 1'b1;
         end
         @(posedge clk); #1;
         chk_reg("rnd");
         chk_out("rnd_out_post", ref_mux(mif.I0, mif.I1, mif.sel));
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux_2x1.md
Name: mux_2x1

Overview:
- Parameterised 2-to-1 word multiplexer, default 5 bits wide. It is used in the MIPS single-cycle datapath for destination-register select (rt vs rd).
- The primary output `out` is purely combinational, so it can sit in the single-cycle path with zero latency.
- A registered copy (`out_q`) and a registered select (`sel_q`) are also provided for pipelined or debug use.
- Clocked state is limited to those two registers.

Parameters:
- WIDTH, 5, data width of I0, I1, out and out_q (legal range 1..32).

Ports:
- clk      input   1      rising-edge clock; drives the registered outputs only.
- rst_n    input   1      asynchronous, active-low reset.
- I0       input   WIDTH  data input, selected when sel=0.
- I1       input   WIDTH  data input, selected when sel=1.
- sel      input   1      select line.
- out      output  WIDTH  combinational result: sel ? I1 : I0.
- out_q    output  WIDTH  registered copy of out.
- sel_q    output  1      registered copy of sel.

Interface:
- One clock (clk).
- Reset (rst_n) is asynchronous and active-low.

Behaviour:
- `out` is combinational, with zero-cycle latency:
  - `out` = I1 when sel=1.
  - `out` = I0 when sel=0.
  - `out` updates in the same delta as any change on I0, I1 or sel.
  - `out` has no dependency on clk or rst_n, and is valid during reset.
- X/Z handling on sel (simulation only):
  - When sel is X/Z and I0==I1, `out` = I0.
  - Otherwise `out` is X.
  - Synthesis ignores this.
- Reset:
  - While rst_n=0, out_q=0 and sel_q=0.
  - Reset assertion takes effect immediately, independent of clk.
  - Deassertion is asynchronous at the flops; the first capture occurs on the first rising clk edge with rst_n=1.
- Registered path:
  - On each rising clk edge with rst_n=1: out_q <= (sel ? I1 : I0) and sel_q <= sel.
  - Latency is 1 cycle.
  - No enable; a capture happens every cycle.
- Reset mid-operation: out_q and sel_q clear to 0 at once. `out` continues to track its inputs.
- Width: no extension or truncation. All data paths are exactly WIDTH bits, with bit i of `out` taken from bit i of the selected input.
- Simultaneous events:
  - A change on sel and data in the same cycle: `out` reflects the final settled values.
  - At the clk edge, out_q captures the values present at the edge.
- No internal state other than out_q and sel_q. No latches are inferred.

Test Plan:
- All inputs 0, sel=0, rst_n=0 held for 2 cycles -> out=00000, out_q=00000, sel_q=0.
- Release rst_n; I0=01010, I1=00110, sel=0 -> out=01010 immediately; out_q=01010, sel_q=0 after the next rising edge.
- Same data, sel=1 -> out=00110 immediately; out_q=00110, sel_q=1 one edge later.
- Toggle sel 0,1,0 at 50 ns intervals with I0=01010, I1=00110 -> out alternates 01010/00110/01010 with no clock dependency; out_q follows one edge behind.
- Assert rst_n=0 mid-run with sel=1 -> out_q=00000 and sel_q=0 without waiting for clk; out stays 00110.
- Edge values I0=11111, I1=00000, toggling sel -> bit-exact 11111/00000, with no bit mixing between inputs.
